// File: rtl/id_stage.sv
// Purpose : LoongArch-style decode stage; decodes one instruction and registers the ALU payload for execute.
// Latency : one cycle from an accepted fetch (if_valid & if_ready) to ex_valid; one instruction per cycle sustained.
// Backpr. : if_ready = !ex_valid | ex_ready; while execute stalls, every ex_* output holds.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_valid/if_ready            fetch handshake; if_pc, if_inst carry the instruction
//   rf_raddr1/2, rf_rdata1/2     register file read port (rj, rk), combinational data return
//   ex_valid/ex_ready            execute handshake; ex_pc, ex_alu_op (one-hot), ex_alu_src1/2,
//                                ex_rf_we, ex_rf_waddr, ex_ine form the payload
//   flush                        drops the held instruction and blocks the incoming one
// Build option: define ID_INE_EN to raise ex_ine for encodings the decoder does not recognise.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [13:0] ex_alu_op,
  output logic [31:0] ex_alu_src1,
  output logic [31:0] ex_alu_src2,
  output logic        ex_rf_we,
  output logic [4:0]  ex_rf_waddr,
  input  logic        flush,
  output logic        ex_ine
);

  // One-hot ALU control bit positions; bits 12-13 are never set.
  localparam int OP_ADD  = 0;
  localparam int OP_PASS = 1;
  localparam int OP_SUB  = 2;
  localparam int OP_SLT  = 3;
  localparam int OP_SLTU = 4;
  localparam int OP_AND  = 5;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 7;
  localparam int OP_XOR  = 8;
  localparam int OP_SLL  = 9;
  localparam int OP_SRL  = 10;
  localparam int OP_SRA  = 11;

  // Instruction fields
  logic [16:0] opc17;
  logic [9:0]  opc10;
  logic [6:0]  opc7;
  logic [4:0]  rd;
  logic [4:0]  ui5;
  logic [11:0] i12;
  logic [19:0] si20;

  assign opc17 = if_inst[31:15];
  assign opc10 = if_inst[31:22];
  assign opc7  = if_inst[31:25];
  assign rd    = if_inst[4:0];
  assign ui5   = if_inst[14:10];
  assign i12   = if_inst[21:10];
  assign si20  = if_inst[24:5];

  assign rf_raddr1 = if_inst[9:5];
  assign rf_raddr2 = if_inst[14:10];

  // Decoded payload
  logic [13:0] dec_op;
  logic [31:0] dec_src1;
  logic [31:0] dec_src2;
  logic        dec_hit;
  logic        dec_we;

  always_comb begin
    dec_op   = '0;
    dec_src1 = '0;
    dec_src2 = '0;
    dec_hit  = 1'b1;

    case (opc17)
      // 3R register-register forms
      17'h00020: begin dec_op[OP_ADD]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h00022: begin dec_op[OP_SUB]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h00024: begin dec_op[OP_SLT]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h00025: begin dec_op[OP_SLTU] = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h00028: begin dec_op[OP_NOR]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h00029: begin dec_op[OP_AND]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h0002A: begin dec_op[OP_OR]   = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h0002B: begin dec_op[OP_XOR]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h0002E: begin dec_op[OP_SLL]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h0002F: begin dec_op[OP_SRL]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      17'h00030: begin dec_op[OP_SRA]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = rf_rdata2; end
      // Shift by 5-bit immediate
      17'h00081: begin dec_op[OP_SLL]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {27'b0, ui5}; end
      17'h00089: begin dec_op[OP_SRL]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {27'b0, ui5}; end
      17'h00091: begin dec_op[OP_SRA]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {27'b0, ui5}; end
      default: begin
        case (opc10)
          // Arithmetic/compare immediates sign-extend, logical immediates zero-extend
          10'h00A: begin dec_op[OP_ADD]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {{20{i12[11]}}, i12}; end
          10'h008: begin dec_op[OP_SLT]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {{20{i12[11]}}, i12}; end
          10'h009: begin dec_op[OP_SLTU] = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {{20{i12[11]}}, i12}; end
          10'h00D: begin dec_op[OP_AND]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {20'b0, i12}; end
          10'h00E: begin dec_op[OP_OR]   = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {20'b0, i12}; end
          10'h00F: begin dec_op[OP_XOR]  = 1'b1; dec_src1 = rf_rdata1; dec_src2 = {20'b0, i12}; end
          default: begin
            case (opc7)
              7'h0A: begin dec_op[OP_PASS] = 1'b1; dec_src1 = {si20, 12'b0}; dec_src2 = '0; end
              7'h0E: begin dec_op[OP_ADD]  = 1'b1; dec_src1 = if_pc; dec_src2 = {si20, 12'b0}; end
              // Unknown encoding: travels on as a PC-carrying bubble
              default: dec_hit = 1'b0;
            endcase
          end
        endcase
      end
    endcase
  end

  // r0 is hardwired zero, so writes to it are suppressed here rather than in the register file
  assign dec_we = dec_hit && (rd != 5'd0);

  // Handshake
  logic load;

  assign if_ready = !ex_valid || ex_ready;
  assign load     = if_valid && if_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_alu_op   <= '0;
      ex_alu_src1 <= '0;
      ex_alu_src2 <= '0;
      ex_rf_we    <= 1'b0;
      ex_rf_waddr <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_alu_op   <= dec_op;
      ex_alu_src1 <= dec_src1;
      ex_alu_src2 <= dec_src2;
      ex_rf_we    <= dec_we;
      ex_rf_waddr <= rd;
    end else if (ex_ready) begin
      // Payload registers keep their last value once drained
      ex_valid <= 1'b0;
    end
  end

`ifdef ID_INE_EN
  logic ine_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ine_q <= 1'b0;
    end else if (!flush && load) begin
      ine_q <= !dec_hit;
    end
  end

  assign ex_ine = ine_q;
`else
  assign ex_ine = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [13:0] ex_alu_op;
  logic [31:0] ex_alu_src1;
  logic [31:0] ex_alu_src2;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        flush;
  logic        ex_ine;

  id_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_alu_op(ex_alu_op), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .flush(flush), .ex_ine(ex_ine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [13:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        we;
    logic [4:0]  wa;
    logic        undef;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic [13:0] op, input logic [31:0] s1,
                              input logic [31:0] s2, input logic we,
                              input logic [4:0] wa, input logic undef);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.ra1 = ra1; v.ra2 = ra2;
    v.op = op; v.s1 = s1; v.s2 = s2; v.we = we; v.wa = wa; v.undef = undef;
    return v;
  endfunction

  // Offers v (holding it) until the stage accepts it; the expected payload is
  // queued at the sample point just before the accepting edge.
  task automatic send(input vec_t v, input logic er);
    bit done = 0;
    @(posedge clk); #1;
    if_valid  = 1'b1;
    if_inst   = v.inst;
    if_pc     = v.pc;
    rf_rdata1 = v.rd1;
    rf_rdata2 = v.rd2;
    ex_ready  = er;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (if_ready === 1'b1) begin
        check("raddr1", {27'b0, rf_raddr1}, {27'b0, v.ra1});
        check("raddr2", {27'b0, rf_raddr2}, {27'b0, v.ra2});
        exp_q.push_back(v);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || ex_valid) && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", {31'b0, exp_q.size() != 0 || ex_valid}, 32'd0);
  endtask

  // Monitor: every completed output handshake must match the oldest queued entry.
  always @(negedge clk) begin
    if (!rst) begin
      check("if_ready_eq", {31'b0, if_ready}, {31'b0, !ex_valid || ex_ready});
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          vec_t e;
          logic exp_ine;
          e = exp_q.pop_front();
`ifdef ID_INE_EN
          exp_ine = e.undef;
`else
          exp_ine = 1'b0;
`endif
          check("ex_pc",   ex_pc, e.pc);
          check("alu_op",  {18'b0, ex_alu_op}, {18'b0, e.op});
          check("src1",    ex_alu_src1, e.s1);
          check("src2",    ex_alu_src2, e.s2);
          check("rf_we",   {31'b0, ex_rf_we}, {31'b0, e.we});
          check("rf_waddr", {27'b0, ex_rf_waddr}, {27'b0, e.wa});
          check("ex_ine",  {31'b0, ex_ine}, {31'b0, exp_ine});
        end
      end
    end
  end

  initial begin
    //            inst          pc            rd1           rd2          ra1  ra2  op        s1            s2            we wa  undef
    vecs[0]  = mk(32'h00101885, 32'h1C000000, 32'd3,        32'd4,       5'd4, 5'd6, 14'h0001, 32'd3,        32'd4,        1, 5'd5, 0); // add.w
    vecs[1]  = mk(32'h02BFFC83, 32'h1C000004, 32'd10,       32'd0,       5'd4, 5'd31,14'h0001, 32'd10,       32'hFFFFFFFF, 1, 5'd3, 0); // addi.w -1
    vecs[2]  = mk(32'h1C000025, 32'h1C000000, 32'd0,        32'd0,       5'd1, 5'd0, 14'h0001, 32'h1C000000, 32'h00001000, 1, 5'd5, 0); // pcaddu12i
    vecs[3]  = mk(32'h00112507, 32'h1C00000C, 32'd10,       32'd3,       5'd8, 5'd9, 14'h0004, 32'd10,       32'd3,        1, 5'd7, 0); // sub.w
    vecs[4]  = mk(32'h142468A1, 32'h1C000010, 32'hDEADBEEF, 32'd0,       5'd5, 5'd26,14'h0002, 32'h12345000, 32'h0,        1, 5'd1, 0); // lu12i.w
    vecs[5]  = mk(32'h0048FC62, 32'h1C000014, 32'h80000000, 32'd7,       5'd3, 5'd31,14'h0800, 32'h80000000, 32'd31,       1, 5'd2, 0); // srai.w 31
    vecs[6]  = mk(32'h037FFCA4, 32'h1C000018, 32'h0F0F0F0F, 32'd0,       5'd5, 5'd31,14'h0020, 32'h0F0F0F0F, 32'h00000FFF, 1, 5'd4, 0); // andi 0xfff
    vecs[7]  = mk(32'h02200020, 32'h1C00001C, 32'd5,        32'd0,       5'd1, 5'd0, 14'h0008, 32'd5,        32'hFFFFF800, 0, 5'd0, 0); // slti rd=r0
    vecs[8]  = mk(32'hFFFFFFFF, 32'h1C000020, 32'h11111111, 32'h22222222,5'd31,5'd31,14'h0000, 32'h0,        32'h0,        0, 5'd31,1); // undecoded
    vecs[9]  = mk(32'h0015B16A, 32'h1C000024, 32'hFF00FF00, 32'h0F0F0F0F,5'd11,5'd12,14'h0100, 32'hFF00FF00, 32'h0F0F0F0F, 1, 5'd10,0); // xor
    vecs[10] = mk(32'h027FFCE6, 32'h1C000028, 32'd1,        32'd0,       5'd7, 5'd31,14'h0010, 32'd1,        32'hFFFFFFFF, 1, 5'd6, 0); // sltui -1
    vecs[11] = mk(32'h03A00049, 32'h1C00002C, 32'h00000001, 32'd0,       5'd2, 5'd0, 14'h0080, 32'h1,        32'h00000800, 1, 5'd9, 0); // ori 0x800

    rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; ex_ready = 1'b1; flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_pc",    ex_pc, 32'd0);
    check("rst_op",    {18'b0, ex_alu_op}, 32'd0);
    check("rst_src1",  ex_alu_src1, 32'd0);
    check("rst_src2",  ex_alu_src2, 32'd0);
    check("rst_we",    {31'b0, ex_rf_we}, 32'd0);
    check("rst_waddr", {27'b0, ex_rf_waddr}, 32'd0);
    check("rst_ine",   {31'b0, ex_ine}, 32'd0);
    check("rst_ready", {31'b0, if_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back stream, execute always ready
    for (int i = 0; i < 8; i++) send(vecs[i], 1'b1);
    idle();
    drain();

    // Stall: hold the undecoded instruction for three cycles with a new one waiting
    send(vecs[8], 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if_valid = 1'b1; if_inst = vecs[9].inst; if_pc = vecs[9].pc;
      rf_rdata1 = vecs[9].rd1; rf_rdata2 = vecs[9].rd2;
      @(negedge clk);
      check("stall_ready", {31'b0, if_ready}, 32'd0);
      check("stall_valid", {31'b0, ex_valid}, 32'd1);
      check("stall_pc",    ex_pc, vecs[8].pc);
      check("stall_op",    {18'b0, ex_alu_op}, {18'b0, vecs[8].op});
      check("stall_src1",  ex_alu_src1, vecs[8].s1);
      check("stall_we",    {31'b0, ex_rf_we}, {31'b0, vecs[8].we});
    end
    send(vecs[9], 1'b1);
    send(vecs[10], 1'b1);
    send(vecs[11], 1'b1);
    idle();
    drain();

    // Flush with a held instruction and a new one offered
    send(vecs[0], 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; if_valid = 1'b1; if_inst = vecs[1].inst; if_pc = vecs[1].pc;
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", {31'b0, ex_valid}, 32'd0);
    @(negedge clk);
    check("flush_valid2", {31'b0, ex_valid}, 32'd0);

    // Reset while stalled drops the held instruction
    send(vecs[2], 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; if_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; ex_ready = 1'b0;
    @(negedge clk);
    check("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_stall_pc",    ex_pc, 32'd0);
    check("rst_stall_op",    {18'b0, ex_alu_op}, 32'd0);
    @(negedge clk);
    check("rst_stall_valid2", {31'b0, ex_valid}, 32'd0);

    // Recovery after reset
    send(vecs[3], 1'b1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 if_valid  input  1  fetch presents instruction; if_pc[31:0], if_inst[31:0] inputs carry it.
REQ-004 if_ready  output  1  stage accepts this cycle; = !ex_valid | ex_ready.
REQ-005 rf_raddr1, rf_raddr2  output  5 each  register file read addresses; = if_inst[9:5] (rj), if_inst[14:10] (rk).
REQ-006 rf_rdata1, rf_rdata2  input  32 each  register file read data, combinational, same cycle.
REQ-007 ex_valid  output  1  execute-side payload valid.
REQ-008 ex_ready  input  1  execute stage accepts payload.
REQ-009 ex_pc  output  32  PC of held instruction.
REQ-010 ex_alu_op  output  14  one-hot ALU control: bit0 ADD, 1 PASS (result=src1), 2 SUB, 3 SLT, 4 SLTU, 5 AND, 6 NOR, 7 OR, 8 XOR, 9 SLL, 10 SRL, 11 SRA, 12-13 reserved (always 0).
REQ-011 ex_alu_src1, ex_alu_src2  output  32 each  ALU operands.
REQ-012 ex_rf_we  output  1;  ex_rf_waddr  output  5  writeback enable and destination (rd = inst[4:0]).
REQ-013 flush  input  1  discard held and incoming instruction.
REQ-014 ex_ine  output  1  instruction-not-exist flag (see Configuration).

Function
REQ-015 Transfer in: if_valid & if_ready & !flush -> all ex_* payload registers load decoded values, ex_valid=1 next cycle.
REQ-016 Transfer out: ex_valid & ex_ready with no transfer in -> ex_valid=0 next cycle; payload registers hold.
REQ-017 ex_valid=1 & ex_ready=0 -> all ex_* outputs hold unchanged (stall); if_ready=0.
REQ-018 Simultaneous out and in (ex_ready=1, if_valid=1) -> new instruction loaded; back-to-back throughput one per cycle, latency one cycle.
REQ-019 flush=1 -> ex_valid=0 next cycle regardless of if_valid/ex_ready; flush wins over transfer in.
REQ-020 3R decode on inst[31:15]: 0x00020 ADD, 0x00022 SUB, 0x00024 SLT, 0x00025 SLTU, 0x00028 NOR, 0x00029 AND, 0x0002A OR, 0x0002B XOR, 0x0002E SLL, 0x0002F SRL, 0x00030 SRA; src1=rf_rdata1, src2=rf_rdata2.
REQ-021 Shift-imm on inst[31:15]: 0x00081 SLL, 0x00089 SRL, 0x00091 SRA; src1=rf_rdata1, src2={27'b0,inst[14:10]}.
REQ-022 2RI12 on inst[31:22]: 0x00A ADD, 0x008 SLT, 0x009 SLTU (src2=sign-extended inst[21:10]); 0x00D AND, 0x00E OR, 0x00F XOR (src2=zero-extended inst[21:10]); src1=rf_rdata1.
REQ-023 inst[31:25]=0x0A (lu12i.w): PASS, src1={inst[24:5],12'b0}, src2=0.
REQ-024 inst[31:25]=0x0E (pcaddu12i): ADD, src1=if_pc, src2={inst[24:5],12'b0}.
REQ-025 ex_rf_we=1 for every decoded instruction with rd!=0; rd==0 -> ex_rf_we=0, payload otherwise normal.
REQ-026 Undecoded encoding: ex_alu_op=0, ex_rf_we=0, src1=src2=0, ex_valid still asserted (instruction flows as bubble-with-PC).
REQ-027 Exactly one ex_alu_op bit set for any decoded instruction.

Reset
REQ-028 rst=1 at clock edge -> ex_valid=0, ex_pc=0, ex_alu_op=0, ex_alu_src1=0, ex_alu_src2=0, ex_rf_we=0, ex_rf_waddr=0, ex_ine=0; rst overrides flush and transfer.
REQ-029 rst asserted mid-stall -> held instruction dropped; no ex_valid on cycle after rst deasserts unless new transfer in occurs.

Configuration
REQ-030 Macro ID_INE_EN defined: ex_ine registered with payload, =1 for undecoded encoding per REQ-026, 0 otherwise.
REQ-031 ID_INE_EN undefined: ex_ine constant 0; undecoded encodings behave exactly as REQ-026 otherwise.

Verification
REQ-032 inst=0x00101885 (add.w r5,r4,r6), rdata1=3, rdata2=4, ex_ready=1 -> next cycle ex_valid=1, alu_op=0x0001, src1=3, src2=4, we=1, waddr=5.
REQ-033 inst=0x02BFFC83 (addi.w r3,r4,-1), rdata1=10 -> alu_op=0x0001, src2=0xFFFFFFFF, waddr=3.
REQ-034 inst=0x1C000025 (pcaddu12i r5,1), if_pc=0x1C000000 -> alu_op=0x0001, src1=0x1C000000, src2=0x00001000.
REQ-035 Hold ex_ready=0 three cycles with if_valid=1 -> if_ready=0, ex_* stable; release -> one instruction per cycle thereafter, none lost or duplicated.
REQ-036 flush=1 with ex_valid=1, if_valid=1 -> ex_valid=0 next cycle; inst=0xFFFFFFFF with ID_INE_EN -> ex_ine=1, alu_op=0, we=0; without -> ex_ine=0.
